// File: rtl/gpr_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpr_writeback_ctrl
// Purpose  : Two-producer (ALU/load) writeback queue for the 8x16 GPR file with
//            RAW hazard reporting; optional bypass data via GPR_WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module gpr_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dest,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_dest,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          wb_en,
  output logic [AW-1:0] wb_dest,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  output logic          hazard_1,
  output logic          hazard_2,
  output logic          byp_valid_1,
  output logic [DW-1:0] byp_data_1,
  output logic          byp_valid_2,
  output logic [DW-1:0] byp_data_2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_t;

  src_t          last_grant_q, last_grant_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          wb_en_q, wb_en_d;
  logic [AW-1:0] wb_dest_q, wb_dest_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic [AW-1:0] dest_q [DEPTH];
  logic [AW-1:0] dest_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          full;
  logic          grant_alu;
  logic          grant_ld;
  logic          push_alu;
  logic          push_ld;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_dest;
  logic [DW-1:0] push_data;

  // Entry age order: slot[0] is the oldest live entry, slot[DEPTH-1] the youngest possible.
  logic [PW-1:0]    slot [DEPTH];
  logic [DEPTH-1:0] match_1;
  logic [DEPTH-1:0] match_2;
  logic             wb_match_1;
  logic             wb_match_2;

  // Ready depends only on full and the tie-break, never on a same-cycle pop.
  assign full      = (count_q == DEPTH_C);
  assign grant_alu = alu_valid && (!ld_valid || (last_grant_q == SRC_LD));
  assign grant_ld  = ld_valid  && (!alu_valid || (last_grant_q == SRC_ALU));
  assign alu_ready = !full && grant_alu;
  assign ld_ready  = !full && grant_ld;
  assign push_alu  = alu_valid && alu_ready;
  assign push_ld   = ld_valid  && ld_ready;
  assign push      = push_alu || push_ld;
  assign pop       = (count_q != '0);
  assign push_dest = push_alu ? alu_dest : ld_dest;
  assign push_data = push_alu ? alu_data : ld_data;

  always_comb begin
    last_grant_d = last_grant_q;
    if (push_alu) begin
      last_grant_d = SRC_ALU;
    end else if (push_ld) begin
      last_grant_d = SRC_LD;
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    dest_d = dest_q;
    data_d = data_q;
    if (push) begin
      dest_d[wr_ptr_q] = push_dest;
      data_d[wr_ptr_q] = push_data;
    end

    wb_en_d   = pop;
    wb_dest_d = pop ? dest_q[rd_ptr_q] : wb_dest_q;
    wb_data_d = pop ? data_q[rd_ptr_q] : wb_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= SRC_LD;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wb_en_q      <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wb_en_q      <= wb_en_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    dest_q <= dest_d;
    data_q <= data_d;
  end

  assign wb_en   = wb_en_q;
  assign wb_dest = wb_dest_q;
  assign wb_data = wb_data_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign slot[g]    = rd_ptr_q + PW'(g);
    assign match_1[g] = (CW'(g) < count_q) && (dest_q[slot[g]] == rd_addr_1);
    assign match_2[g] = (CW'(g) < count_q) && (dest_q[slot[g]] == rd_addr_2);
  end

  // The wb-stage write has not reached the GPR yet, so it still counts as pending.
  assign wb_match_1 = wb_en_q && (wb_dest_q == rd_addr_1);
  assign wb_match_2 = wb_en_q && (wb_dest_q == rd_addr_2);
  assign hazard_1   = wb_match_1 || (|match_1);
  assign hazard_2   = wb_match_2 || (|match_2);

`ifdef GPR_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    byp_data_1 = '0;
    byp_data_2 = '0;
    if (wb_match_1) byp_data_1 = wb_data_q;
    if (wb_match_2) byp_data_2 = wb_data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_1[i]) byp_data_1 = data_q[slot[i]];
      if (match_2[i]) byp_data_2 = data_q[slot[i]];
    end
  end
  assign byp_valid_1 = hazard_1;
  assign byp_valid_2 = hazard_2;
`else
  assign byp_valid_1 = 1'b0;
  assign byp_valid_2 = 1'b0;
  assign byp_data_1  = '0;
  assign byp_data_2  = '0;
`endif

endmodule
`default_nettype wire
